// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller: issues one held-valid bus
// transaction per load/store, stalls until data_ok, extends load data.
package dbus_pkg;
    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module mem_access_ctrl
    import dbus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  access_size,
    input  logic        load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        advance,
    input  dbus_resp_t  resp,
    output dbus_req_t   req,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wd_q, wd_d;
    logic        sgn_q, sgn_d;
    logic        load_q, load_d;
    logic [31:0] data_q, data_d;

    logic [1:0]  size_n;
    logic        access;
    logic        misaligned;
    logic        issue;
    logic [3:0]  strb_in;
    logic [31:0] wd_in;
    logic [31:0] sh;

    function automatic logic [1:0] enc_size(input logic [1:0] s);
        case (s)
            2'd0:    enc_size = MSIZE1;
            2'd1:    enc_size = MSIZE2;
            default: enc_size = MSIZE4;
        endcase
    endfunction

    // size 3 is folded into word so every later decision sees 0/1/2 only
    assign size_n = (access_size == 2'd3) ? 2'd2 : access_size;
    assign access = mem_read | mem_write;
    assign misaligned = ((size_n == 2'd1) && addr[0]) ||
                        ((size_n == 2'd2) && (addr[1:0] != 2'b00));
    assign addr_err = access & misaligned;
    assign issue = (state_q == IDLE) && access && !misaligned;

    always_comb begin
        strb_in = 4'b0000;
        wd_in   = wdata;
        case (size_n)
            2'd0: begin
                wd_in = {4{wdata[7:0]}};
                if (mem_write) strb_in = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                wd_in = {2{wdata[15:0]}};
                if (mem_write) strb_in = 4'b0011 << addr[1:0];
            end
            default: begin
                wd_in = wdata;
                if (mem_write) strb_in = 4'b1111;
            end
        endcase
    end

    always_comb begin
        req.valid  = 1'b0;
        req.addr   = addr_q;
        req.size   = enc_size(size_q);
        req.strobe = strb_q;
        req.data   = wd_q;
        if (issue) begin
            req.valid  = 1'b1;
            req.addr   = addr;
            req.size   = enc_size(size_n);
            req.strobe = strb_in;
            req.data   = wd_in;
        end else if (state_q == REQ) begin
            req.valid = 1'b1;
        end
    end

    assign stall = issue || (state_q == REQ) || (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        strb_d  = strb_q;
        wd_d    = wd_q;
        sgn_d   = sgn_q;
        load_d  = load_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    addr_d = addr;
                    size_d = size_n;
                    strb_d = strb_in;
                    wd_d   = wd_in;
                    sgn_d  = load_signed;
                    load_d = mem_read;
                    if (resp.addr_ok && resp.data_ok) begin
                        state_d = DONE;
                        data_d  = resp.data;
                    end else if (resp.addr_ok) begin
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (resp.addr_ok && resp.data_ok) begin
                    state_d = DONE;
                    data_d  = resp.data;
                end else if (resp.addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (resp.data_ok) begin
                    state_d = DONE;
                    data_d  = resp.data;
                end
            end
            default: begin
                if (advance) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            strb_q  <= '0;
            wd_q    <= '0;
            sgn_q   <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            strb_q  <= strb_d;
            wd_q    <= wd_d;
            sgn_q   <= sgn_d;
            load_q  <= load_d;
            data_q  <= data_d;
        end
    end

    // load data comes only from the captured register, never live resp
    assign sh = data_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        rdata = '0;
        if ((state_q == DONE) && load_q) begin
            case (size_q)
                2'd0:    rdata = {{24{sgn_q & sh[7]}}, sh[7:0]};
                2'd1:    rdata = {{16{sgn_q & sh[15]}}, sh[15:0]};
                default: rdata = data_q;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage data-bus access controller for the pipelined CPU. It sits between the MEM stage datapath and the `dbus_req_t`/`dbus_resp_t` port. It turns one load/store per instruction into a held-valid bus transaction, stalls the pipeline until the data handshake completes, and generates size, strobe and lane-replicated write data. It also extracts and sign/zero-extends load data and flags misaligned accesses without issuing them.

## Interface
- No parameters.
- `clk` in 1: clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `mem_read` in 1: current MEM-stage instruction is a load.
- `mem_write` in 1: current MEM-stage instruction is a store. Never high together with `mem_read`.
- `access_size` in 2: 0 = byte, 1 = half, 2 = word. 3 is illegal and treated as word.
- `load_signed` in 1: sign-extend load result (LB/LH). 0 = zero-extend (LBU/LHU). Ignored for word.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data, right-aligned.
- `advance` in 1: pipeline moves the MEM-stage instruction onward this cycle.
- `resp` in `dbus_resp_t`: `addr_ok`, `data_ok`, `data`.
- `req` out `dbus_req_t`: `valid`, `addr`, `size`, `strobe`, `data`.
- `stall` out 1: hold the MEM stage and everything upstream.
- `rdata` out 32: extended load result. Valid in DONE.
- `addr_err` out 1: misaligned access. Combinational from inputs.

## Operation
- **Alignment.** Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `addr_err` = (`mem_read`|`mem_write`) & misaligned.
  - A misaligned access issues no request, raises no `stall`, and leaves the FSM in IDLE.
- **Request encoding.**
  - `req.addr` = `addr`.
  - `req.size`: byte → MSIZE1, half → MSIZE2, word → MSIZE4.
  - `req.strobe`: store byte → 4'b0001<<addr[1:0]; store half → 4'b0011<<addr[1:0]; store word → 4'b1111; loads → 4'b0000.
  - `req.data`: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE.**
  - Aligned access present: `req.valid`=1 with fields driven combinationally from the inputs, and the fields are latched into the request register. `stall`=1.
  - `addr_ok`&`data_ok` → DONE, capture `resp.data`.
  - `addr_ok` only → WAIT.
  - Neither → REQ.
  - No access present: `req.valid`=0, `stall`=0.
- **REQ.** `req.valid`=1 with the latched fields, which stay stable until `addr_ok`. `stall`=1. Same transitions as IDLE.
- **WAIT.** `req.valid`=0, `stall`=1. `data_ok` → DONE and capture `resp.data`.
- **DONE.** `stall`=0. `rdata` is taken from the captured data register, never from `resp`.
  - `advance` → IDLE. A back-to-back access is then evaluated in the following cycle.
  - DONE is held while `advance`=0. The same instruction is never re-issued.
- **Load extraction.**
  - sh = captured >> (8·latched addr[1:0]).
  - Byte: {{24{load_signed & sh[7]}}, sh[7:0]}.
  - Half: {{16{load_signed & sh[15]}}, sh[15:0]}.
  - Word: the captured data unchanged.
  - Store: `rdata` = 0.
- `addr_ok`/`data_ok` seen outside REQ/WAIT/IDLE-issuing are ignored.

## Timing
- Reset values: state = IDLE, `req.valid`=0, `stall`=0, `rdata`=0, latched fields and captured data = 0.
- **Reset mid-operation:** in any state, the FSM returns to IDLE next cycle with `req.valid`=0. A late `data_ok` arriving after reset is ignored.
- **Latency:** minimum one stall cycle (`addr_ok`&`data_ok` in the issue cycle → DONE next cycle). General case: stall cycles = cycles to `addr_ok` + cycles from `addr_ok` to `data_ok` + 1.
- `req.valid`, once asserted, stays asserted with unchanged fields until the cycle `addr_ok` is sampled high.
- At most one outstanding transaction at any time.
- `stall` depends combinationally on `mem_read`/`mem_write`/alignment in IDLE only. In other states it depends on the registered state.

## Test plan
- **Zero-wait load.** LW addr=0x100, `addr_ok`=`data_ok`=1 in the issue cycle, data=0xDEADBEEF → `stall` high for exactly 1 cycle, then DONE with `rdata`=0xDEADBEEF. `advance` → IDLE.
- **Delayed handshake.** SB addr=0x103 wdata=0x000000A5; `addr_ok` after 2 cycles, `data_ok` 3 cycles later → `req.strobe`=4'b1000 and `req.data`=0xA5A5A5A5, both stable for 3 cycles. `stall` lasts 6 cycles. `req.valid` drops after `addr_ok`.
- **Load extension.** Bus data 0x80F1_7F00. LB addr=0x2 → 0xFFFFFFF1. LBU addr=0x2 → 0x000000F1. LH addr=0x2 → 0xFFFF80F1. LHU addr=0x0 → 0x00007F00.
- **Misaligned.** LW addr=0x102 and SH addr=0x101 → `addr_err`=1, `req.valid`=0, `stall`=0, FSM stays IDLE.
- **Hold in DONE.** Access completes with `advance`=0 for 4 cycles → no second `req.valid`, `rdata` stable, `stall`=0.
- **Reset in WAIT.** `reset` pulsed after `addr_ok`, then `data_ok` arrives → IDLE, `stall`=0, `rdata`=0, no DONE entry.
